conv1_window_sequencer: RTL and testbench
=========================================

Name: conv1_window_sequencer

Overview:
- Sequences the first 1-D convolution layer of the ECG classifier over one input beat.
- Accepts 8-bit quantized samples on a valid/ready stream and builds the 5-tap sliding window, stride 1.
- Drives the 4-channel conv datapath's window and enable, waits out its latency, and captures the four clamped 8-bit channel results.
- Emits one 4-channel output word per window position on a valid/ready stream to the next layer.

Parameters:
SIG_LEN, 187, samples per input frame (one ECG beat); must be >= 5
KSIZE, 5, kernel taps; fixed at 5 to match the layer-1 datapath
CONV_LAT, 1, cycles from conv_en assertion to valid ch0..ch3; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid && in_ready
in_data  in  8  signed sample
conv_en  out  1  enable to conv datapath, one-cycle pulse per window
conv_win  out  5x8  signed window; conv_win[0] oldest, conv_win[4] newest
ch0..ch3  in  8 each  signed clamped channel results from datapath
out_valid  out  1  result word valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  4x8  {ch3,ch2,ch1,ch0} captured
out_idx  out  $clog2(SIG_LEN)  output position within frame, 0-based
frame_done  out  1  one-cycle pulse on final output handshake
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; in_ready=0, conv_en=0, out_valid=0, frame_done=0, busy=0.
  - conv_win, out_data, out_idx, and the sample and latency counters all clear to 0.
- IDLE: in_ready=1. On an accepted sample, shift it in and go to FILL with sample count=1.
- Shifting: conv_win[i] <= conv_win[i+1] for i=0..3; conv_win[4] <= in_data.
- FILL:
  - in_ready=1; each accepted sample is shifted in and the sample count increments.
  - When the window holds KSIZE valid samples, go to ISSUE the next cycle.
  - in_valid gaps hold state.
- ISSUE: conv_en=1 for exactly one cycle, in_ready=0, window frozen; load the latency counter with CONV_LAT; go to WAIT.
- WAIT:
  - Count down CONV_LAT cycles with window frozen and conv_en=0.
  - On expiry, capture ch0..ch3 into out_data and go to EMIT.
- EMIT:
  - out_valid=1; out_data and out_idx are stable until the handshake.
  - On handshake, if out_idx == last index: pulse frame_done, clear out_idx and the sample count, and return to IDLE.
  - Otherwise out_idx++ and go to SLIDE.
- SLIDE: in_ready=1; accept exactly one sample, shift it in, then go to ISSUE.
- Output count per frame: SIG_LEN-4; last index = SIG_LEN-5.
- No input overlap: in_ready=0 in ISSUE, WAIT, and EMIT. Each sample is accepted exactly once.
- Backpressure: out_ready=0 holds EMIT indefinitely with no output or state change.
- Frame boundaries: back-to-back frames are allowed; the first sample of frame k+1 is accepted in IDLE the cycle after frame_done.
- Reset mid-frame: abandon the frame with no frame_done; the next sample starts a new frame at out_idx 0.
- Arithmetic: counters are unsigned and never wrap within a frame. Data is passed through unmodified; no arithmetic is done on samples.

Optional Feature:
- Macro: CONV1_ZERO_PAD_EN.
- Defined ("same" padding, 2 zeros each side):
  - Window preloads 0 at frame start; the first ISSUE follows the 3rd accepted sample, giving window {0,0,x0,x1,x2}.
  - After the last sample, SLIDE shifts in 0 without asserting in_ready, for 2 extra positions.
  - Outputs per frame = SIG_LEN; last index = SIG_LEN-1.
- Undefined: "valid" convolution as specified above (SIG_LEN-4 outputs).

Decomposition:
- Package conv1_pkg:
  - typedef sample_t (logic signed [7:0]) and window_t (sample_t [4:0]);
  - state enum {IDLE, FILL, ISSUE, WAIT, EMIT, SLIDE};
  - localparams KSIZE=5 and PAD=2.
- Sub-module conv1_window_shreg: the 5x8 shift register with shift-enable, zero-shift select, and synchronous clear.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with in_valid=1 -> every output 0, in_ready=0; after release in_ready=1 within 1 cycle.
2. SIG_LEN=8, CONV_LAT=1, ramp in_data 1..8, out_ready=1 -> 4 outputs, idx 0..3, windows {1..5},{2..6},{3..7},{4..8}; frame_done on idx 3; exactly 4 conv_en pulses.
3. Same frame with out_ready low 10 cycles at idx 1 -> out_data/out_idx stable, in_ready=0 throughout, no extra conv_en; sequence resumes intact.
4. in_valid toggled 1-0-1 every cycle, CONV_LAT=3 -> identical output sequence to test 2; conv_en to capture = 3 cycles.
5. rst pulsed in WAIT at idx 2, then new ramp 11..18 -> no frame_done before reset; first output idx 0 with window {11..15}.
6. CONV1_ZERO_PAD_EN, SIG_LEN=8, ramp 1..8 -> 8 outputs, first window {0,0,1,2,3}, last {7,8,0,0}-style tail {6,7,8,0,0}; 8 samples accepted.

Source files
------------

// File: rtl/conv1_pkg.sv
// conv1_pkg: shared types and constants for the layer-1 conv window sequencer.
package conv1_pkg;
  localparam int KSIZE = 5;
  localparam int PAD = 2;
  typedef logic signed [7:0] sample_t;
  typedef sample_t [KSIZE-1:0] window_t;
  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, EMIT, SLIDE} state_t;
endpackage

// File: rtl/conv1_window_shreg.sv
// conv1_window_shreg: 5-tap sample window; element 0 oldest, element 4 newest.
module conv1_window_shreg
  import conv1_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            shift,
  input  logic            zero,
  input  logic            clr,
  input  logic [7:0]      din,
  output logic [4:0][7:0] win
);
  sample_t fill;
  assign fill = zero ? sample_t'(0) : sample_t'(din);
  always_ff @(posedge clk or negedge rst)
    if (!rst) win <= '0;
    else if (clr) win <= '0;
    else if (shift) win <= {fill, win[4:1]};
endmodule

// File: rtl/conv1_window_sequencer.sv
// conv1_window_sequencer: drives the layer-1 conv datapath one window per output.
// Defining CONV1_ZERO_PAD_EN selects "same" padding (2 zeros each side).
module conv1_window_sequencer
  import conv1_pkg::*;
#(
  parameter int SIG_LEN  = 187,
  parameter int CONV_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_data,
  output logic                       conv_en,
  output logic [4:0][7:0]            conv_win,
  input  logic [7:0]                 ch0,
  input  logic [7:0]                 ch1,
  input  logic [7:0]                 ch2,
  input  logic [7:0]                 ch3,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [$clog2(SIG_LEN)-1:0] out_idx,
  output logic                       frame_done,
  output logic                       busy
);
  localparam int IW = $clog2(SIG_LEN);
  localparam int CW = $clog2(SIG_LEN + 1);
  localparam int LW = $clog2(CONV_LAT + 1);
`ifdef CONV1_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
  localparam int FILL_N = KSIZE - PAD;
  localparam int NOUT = SIG_LEN;
`else
  localparam bit PAD_EN = 1'b0;
  localparam int FILL_N = KSIZE;
  localparam int NOUT = SIG_LEN - KSIZE + 1;
`endif
  localparam logic [IW-1:0] LAST = IW'(NOUT - 1);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lat;
  logic acc, tail;
  assign acc = in_valid && in_ready;
  // once every sample is in, padded slides feed zeros instead of waiting on input
  assign tail = PAD_EN && cnt == CW'(SIG_LEN);
  assign busy = state != IDLE;
  conv1_window_shreg u_shreg (
    .clk  (clk),
    .rst  (rst),
    .shift(acc || (state == SLIDE && tail)),
    .zero (tail),
    .clr  (PAD_EN && frame_done),
    .din  (in_data),
    .win  (conv_win)
  );
  always_comb begin
    nxt = state;
    in_ready = 1'b0;
    conv_en = 1'b0;
    out_valid = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        nxt = in_valid ? FILL : IDLE;
      end
      FILL: begin
        in_ready = 1'b1;
        nxt = (in_valid && cnt == CW'(FILL_N - 1)) ? ISSUE : FILL;
      end
      ISSUE: begin
        conv_en = 1'b1;
        nxt = WAIT;
      end
      WAIT: nxt = (lat == LW'(1)) ? EMIT : WAIT;
      EMIT: begin
        out_valid = 1'b1;
        frame_done = out_ready && out_idx == LAST;
        nxt = !out_ready ? EMIT : frame_done ? IDLE : SLIDE;
      end
      SLIDE: begin
        in_ready = !tail;
        nxt = (in_valid || tail) ? ISSUE : SLIDE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      lat <= '0;
      out_idx <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      cnt <= frame_done ? '0 : acc ? cnt + 1'b1 : cnt;
      lat <= (state == ISSUE) ? LW'(CONV_LAT) : (state == WAIT) ? lat - 1'b1 : lat;
      out_idx <= frame_done ? '0 : (out_valid && out_ready) ? out_idx + 1'b1 : out_idx;
      if (state == WAIT && lat == LW'(1)) out_data <= {ch3, ch2, ch1, ch0};
    end
endmodule

// File: tb/tb_conv1_window_sequencer.sv
// tb_conv1_window_sequencer: randomized bench with a window/datapath reference model.
module tb_conv1_window_sequencer;
  localparam int SIG_LEN = 8;
  localparam int LAT = 3;
`ifdef CONV1_ZERO_PAD_EN
  localparam int PADN = 2;
  localparam int NOUT = SIG_LEN;
`else
  localparam int PADN = 0;
  localparam int NOUT = SIG_LEN - 4;
`endif
  localparam int IW = $clog2(SIG_LEN);
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic in_ready, conv_en, out_valid, frame_done, busy;
  logic [7:0] in_data = 0, ch0, ch1, ch2, ch3;
  logic [4:0][7:0] conv_win;
  logic [31:0] out_data;
  logic [IW-1:0] out_idx;
  int checks = 0, errors = 0;
  logic [7:0] x [SIG_LEN];
  logic [7:0] fr [SIG_LEN];
  logic [31:0] pipe [LAT+1];
  int nacc = 0, nconv = 0, nout = 0, done_cnt = 0, rmode = 0, stall_n = 0;
  logic stalled = 0;
  logic [31:0] p_data;
  logic [IW-1:0] p_idx;

  always #5 clk = ~clk;

  conv1_window_sequencer #(.SIG_LEN(SIG_LEN), .CONV_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .conv_en(conv_en), .conv_win(conv_win), .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .frame_done(frame_done), .busy(busy)
  );

  task automatic check(string tag, logic [39:0] got, logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // window k over the (optionally zero-padded) accepted sample sequence
  function automatic logic [39:0] win_at(int k);
    logic [39:0] w = '0;
    for (int j = 0; j < 5; j++) begin
      int p = k + j - PADN;
      if (p >= 0 && p < SIG_LEN) w[j*8 +: 8] = x[p];
    end
    return w;
  endfunction

  function automatic logic [31:0] dp(logic [39:0] w);
    return {w[31:24], w[23:16], w[15:8], w[7:0] ^ w[39:32]};
  endfunction

  // datapath stand-in: result valid exactly LAT cycles after conv_en, noise otherwise
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = conv_en ? dp(conv_win) : $urandom;
    {ch3, ch2, ch1, ch0} = pipe[LAT];
  end

  always @(negedge clk) if (rst) begin
    if (in_valid && in_ready) begin
      check("acc_room", nacc < SIG_LEN, 1);
      if (nacc < SIG_LEN) x[nacc] = in_data;
      nacc++;
    end
    if (conv_en) begin
      check("win", conv_win, win_at(nconv));
      check("conv_idx", out_idx, nconv);
      nconv++;
    end
    if (out_valid) check("emit_quiet", {in_ready, conv_en}, 0);
    if (out_valid && out_ready) begin
      check("idx", out_idx, nout);
      check("data", out_data, dp(win_at(nout)));
      check("fdone", frame_done, nout == NOUT - 1);
      nout++;
      if (frame_done) begin
        check("n_acc", nacc, SIG_LEN);
        check("n_conv", nconv, NOUT);
        nacc = 0; nconv = 0; nout = 0;
        done_cnt++;
      end
    end else check("fdone_idle", frame_done, 0);
    if (out_valid && !out_ready) begin
      if (stalled) begin
        check("hold_data", out_data, p_data);
        check("hold_idx", out_idx, p_idx);
      end
      stalled = 1; p_data = out_data; p_idx = out_idx;
    end else stalled = 0;
  end

  always @(posedge clk) begin
    #1;
    if (rmode == 2 && out_valid && out_idx == 1 && stall_n < 10) begin
      out_ready = 0;
      stall_n++;
    end else out_ready = (rmode == 1) ? ($urandom % 3 != 0) : 1'b1;
  end

  task automatic send(int first, int count, int vmode);
    for (int i = first; i < first + count; i++) begin
      int gap = (vmode == 1) ? 1 : (vmode == 2) ? int'($urandom_range(0, 2)) : 0;
      int t = 0;
      logic a = 0;
      repeat (gap) begin in_valid = 0; @(posedge clk); #1; end
      in_valid = 1; in_data = fr[i];
      do begin @(negedge clk); a = in_ready; @(posedge clk); #1; t++; end while (!a && t < 300);
      check("accept", a, 1);
      in_valid = 0;
    end
  endtask

  task automatic frame(int vmode);
    int n = done_cnt + 1;
    int t = 0;
    send(0, SIG_LEN, vmode);
    while (done_cnt < n && t < 1000) begin @(posedge clk); t++; end
    #1;
    check("frame_done_seen", done_cnt, n);
  endtask

  task automatic ramp(int base);
    for (int i = 0; i < SIG_LEN; i++) fr[i] = 8'(base + i);
  endtask

  initial begin
    int t, c0;
    logic hit;
    in_valid = 1; in_data = 8'h5a;
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_ctrl", {conv_en, out_valid, frame_done, busy}, 0);
      check("rst_win", conv_win, 0);
      check("rst_out", {out_data, out_idx}, 0);
    end
    @(posedge clk); #1; in_valid = 0; rst = 1;
    @(negedge clk); check("rdy_after_rst", in_ready, 1);
    @(posedge clk); #1;
    ramp(1); frame(0);
    stall_n = 0; rmode = 2; ramp(1); frame(0);
    check("stall_len", stall_n, 10);
    rmode = 0; ramp(1); frame(1);
    c0 = done_cnt; ramp(1);
    send(0, 7 - PADN, 0);
    t = 0; hit = 0;
    while (!hit && t < 100) begin @(negedge clk); hit = conv_en && out_idx == 2; t++; end
    check("reach_idx2", hit, 1);
    @(posedge clk); #1; rst = 0;
    nacc = 0; nconv = 0; nout = 0; stalled = 0;
    repeat (2) @(posedge clk);
    #1; rst = 1;
    check("no_done_on_rst", done_cnt, c0);
    ramp(11); frame(0);
    rmode = 1;
    repeat (4) begin
      for (int i = 0; i < SIG_LEN; i++) fr[i] = 8'($urandom);
      frame(2);
    end
    rmode = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
